// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  uart_pkg : shared types and constants for the UART receive path
//  Rev 1.0  : initial release
// ============================================================================
package uart_pkg;

    localparam int   BPS_CNT_W     = 13;
    localparam logic UART_IDLE_LVL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_bit_timer.sv
`default_nettype none
// ============================================================================
//  uart_rx_bit_timer : free-running bit-period counter with half/full ticks
//  Rev 1.0  : initial release
// ============================================================================
module uart_rx_bit_timer
    import uart_pkg::*;
#(
    parameter int BPS_PARA = 625
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick_half,
    output logic tick_full
);

    localparam logic [BPS_CNT_W-1:0] HALF_LAST = BPS_CNT_W'(BPS_PARA / 2 - 1);
    localparam logic [BPS_CNT_W-1:0] FULL_LAST = BPS_CNT_W'(BPS_PARA - 1);

    logic [BPS_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick_full) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + BPS_CNT_W'(1);
        end
    end

    assign tick_half = (cnt == HALF_LAST);
    assign tick_full = (cnt == FULL_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  uart_rx : 8N1-style UART receiver, mid-bit sampling, 1-cycle strobes.
//  Optional parity bit enabled by defining UART_RX_PARITY_EN.
//  Rev 1.0  : initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int BPS_PARA   = 625,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);

    rx_state_t            state, state_next;
    logic                 sync1, rx_s, rx_q;
    logic                 tick_half, tick_full, timer_clear;
    logic                 shift_en, par_chk;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg, data_q;
    logic                 parity_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= UART_IDLE_LVL;
            rx_s  <= UART_IDLE_LVL;
            rx_q  <= UART_IDLE_LVL;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
            rx_q  <= rx_s;
        end
    end

    assign timer_clear = (state == IDLE) || (state_next != state);

    uart_rx_bit_timer #(
        .BPS_PARA (BPS_PARA)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clear),
        .tick_half (tick_half),
        .tick_full (tick_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rx_valid   = 1'b0;
        frame_err  = 1'b0;
        shift_en   = 1'b0;
        par_chk    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_q && !rx_s) state_next = START;
            end
            START: begin
                if (tick_half) state_next = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (tick_full) begin
                    shift_en = 1'b1;
                    if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick_full) begin
                    par_chk    = 1'b1;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                // Leaving at mid-stop-bit keeps half a bit of slack for a back-to-back start.
                if (tick_full) begin
                    rx_valid   = rx_s;
                    frame_err  = !rx_s;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            data_q     <= '0;
            bit_idx    <= '0;
            parity_bad <= 1'b0;
        end else begin
            if (state == IDLE) begin
                bit_idx    <= '0;
                parity_bad <= 1'b0;
            end
            if (shift_en) begin
                shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                bit_idx <= bit_idx + 4'd1;
            end
            if (par_chk) begin
                parity_bad <= (rx_s != ((^shreg) ^ PARITY_ODD[0]));
            end
            if (rx_valid) begin
                data_q <= shreg;
            end
        end
    end

    // Bypass so the new byte is already visible in the strobe cycle.
    assign rx_data = rx_valid ? shreg : data_q;
    assign busy    = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    assign parity_err = rx_valid && parity_bad;
`else
    logic unused_parity_bits;
    assign unused_parity_bits = PARITY_ODD[0] ^ parity_bad ^ par_chk;
    assign parity_err         = 1'b0;
`endif

endmodule
`default_nettype wire
